rr_arbiter_16: RTL

- Round-robin arbiter that shares one 16-way resource among 16 requesters.
- Issues a registered one-hot grant plus its 4-bit encoded index; the one-hot grant is the decode of the index.
- Sits in front of decoder-selected resources (chip-selects, bank enables) so that only one requester drives the shared path at a time.
- Grants are held until the owner drops its request. Arbitration is fair by rotating priority.

---
 rtl/rr_arbiter_16.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_16.sv
// -----------------------------------------------------------------------------
// rr_arbiter_16
//   Round-robin arbiter sharing one resource among 16 requesters. A winner is
//   found combinationally from the current request vector, starting one past
//   the last owner, and registered as a one-hot grant plus its 4-bit index.
//   The owner keeps the grant until it drops its request. On release, the
//   next winner is granted on the same edge, so there is no idle cycle.
//
//   Optional feature (macro GRANT_TIMEOUT_EN): a hold counter forces a
//   one-cycle revoke when the owner exceeds HOLD_MAX cycles while others wait.
//   Without the macro, grants are held indefinitely and timeout_o is 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request vector, bit i = requester i (level, held while owning)
//   arb_en     1 allows new grants; 0 blocks new grants, never revokes
//   gnt        registered one-hot grant, zero when no grant
//   gnt_idx    registered index of current/last owner
//   gnt_valid  registered, 1 when gnt is nonzero
//   timeout_o  one-cycle pulse on a forced revoke
// -----------------------------------------------------------------------------
module rr_arbiter_16 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        arb_en,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid,
   output logic        timeout_o
);

   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
      $error("rr_arbiter_16: HOLD_MAX must be in 2..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1
`ifdef GRANT_TIMEOUT_EN
      ,
      REVOKE = 2'd2
`endif
   } state_t;

   state_t      state_q;
   logic [15:0] gnt_q;
   logic [3:0]  idx_q;
   logic        vld_q;
   logic        to_q;
   logic [3:0]  ptr_q;

`ifdef GRANT_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   logic [7:0]  cnt_q;
   logic        others_req;
   assign others_req = |(req & ~(16'(1) << idx_q));
`endif

   // Returns {found, index}: first set bit of r searching base+1 upward with
   // wrap-around; base itself is checked last.
   function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] base);
      logic [4:0] res;
      logic [3:0] idx;
      res = '0;
      // Walk from farthest to nearest so the nearest set bit is written last.
      for (int i = 16; i >= 1; i--) begin
         idx = base + 4'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // While granted, the owner is about to become the pointer on release, so
   // searching from the owner gives the no-bubble handover its correct start.
   logic [3:0] search_base;
   logic [4:0] pick;
   logic       pick_vld;
   logic [3:0] pick_idx;

   assign search_base = (state_q == GRANT) ? idx_q : ptr_q;
   assign pick        = rr_pick(req, search_base);
   assign pick_vld    = pick[4];
   assign pick_idx    = pick[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= 4'd15;
`ifdef GRANT_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         to_q <= 1'b0;
         case (state_q)
            GRANT: begin
               if (!req[idx_q]) begin
                  ptr_q <= idx_q;
                  if (arb_en && pick_vld) begin
                     gnt_q   <= 16'(1) << pick_idx;
                     idx_q   <= pick_idx;
                     vld_q   <= 1'b1;
                     state_q <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                     cnt_q   <= '0;
`endif
                  end else begin
                     gnt_q   <= '0;
                     vld_q   <= 1'b0;
                     state_q <= IDLE;
                  end
               end
`ifdef GRANT_TIMEOUT_EN
               else if (cnt_q == HOLD_LAST && others_req) begin
                  // Owner overstayed while others wait: drop for one cycle.
                  gnt_q   <= '0;
                  vld_q   <= 1'b0;
                  to_q    <= 1'b1;
                  ptr_q   <= idx_q;
                  state_q <= REVOKE;
               end else if (cnt_q != HOLD_LAST) begin
                  cnt_q <= cnt_q + 8'd1;
               end
`endif
            end
            // IDLE and the revoke cycle both arbitrate afresh from ptr_q.
            default: begin
               if (arb_en && pick_vld) begin
                  gnt_q   <= 16'(1) << pick_idx;
                  idx_q   <= pick_idx;
                  vld_q   <= 1'b1;
                  state_q <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end else begin
                  gnt_q   <= '0;
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = vld_q;
   assign timeout_o = to_q;

endmodule
